// File: rtl/reg_move_sequencer.sv
// reg_move_sequencer
//   Control stage between instruction decode and the 8-bit register file.
//   Takes one register-transfer micro-instruction at a time over a
//   valid/ready handshake and sequences it onto the register file ports
//   and the shared bus. RD results come back over a valid/ready channel.
//
//   Ports
//     clk, rst_n        clock, synchronous active-low reset
//     instr_valid/ready instruction handshake
//     instr_op          00 MOV, 01 LDI, 10 RD, 11 NOP
//     instr_dst/src/imm instruction fields
//     r_addr, w_addr    register file read / write address (registered)
//     bus_out, bus_oe   bus write data and drive enable (registered)
//     bus_in            sampled bus value
//     out_valid/ready   RD result handshake, out_data the result
//     busy              sequencer is not in IDLE
//     op_count          retired-instruction counter (wraps)
module reg_move_sequencer #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int NULL_ADDR = 0,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [1:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_dst,
  input  logic [ADDR_W-1:0] instr_src,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [ADDR_W-1:0] r_addr,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic [DATA_W-1:0] bus_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, OUT_WAIT} state_t;

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_LDI = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;

  localparam logic [ADDR_W-1:0] NULL_A = ADDR_W'(NULL_ADDR);

  state_t            state;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] src_q;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] captured;

  // Nobody drives the bus when the null register is read, so its value is
  // meaningless (possibly X/Z); substitute zero instead of sampling it.
  assign captured = (src_q == NULL_A) ? '0 : bus_in;

  assign instr_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  // The hold register only changes at the end of READ, so the RD result is
  // stable for the whole OUT_WAIT stall.
  assign out_data    = hold;

  // Register-file-facing outputs are loaded on the edge that enters the
  // state using them, so they are plain flop outputs during that state.
  // NOTE: every register here is assigned with <= so all updates in this
  // block see the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= OP_MOV;
      dst_q     <= '0;
      src_q     <= '0;
      hold      <= '0;
      r_addr    <= '0;
      w_addr    <= '0;
      bus_out   <= '0;
      bus_oe    <= 1'b0;
      out_valid <= 1'b0;
      op_count  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (instr_valid) begin
            op_q  <= instr_op;
            dst_q <= instr_dst;
            src_q <= instr_src;
            case (instr_op)
              OP_MOV, OP_RD: begin
                state  <= READ;
                r_addr <= instr_src;
              end
              OP_LDI: begin
                state   <= WRITE;
                w_addr  <= instr_dst;
                bus_out <= instr_imm;
                bus_oe  <= 1'b1;
              end
              default: op_count <= op_count + CNT_W'(1); // NOP retires now
            endcase
          end
        end

        READ: begin
          // Dropping r_addr here guarantees the register file has released
          // the bus before bus_oe rises in WRITE.
          r_addr <= NULL_A;
          hold   <= captured;
          if (op_q == OP_RD) begin
            state     <= OUT_WAIT;
            out_valid <= 1'b1;
          end else begin
            state   <= WRITE;
            w_addr  <= dst_q;
            bus_out <= captured;
            bus_oe  <= 1'b1;
          end
        end

        WRITE: begin
          state    <= IDLE;
          w_addr   <= NULL_A;
          bus_out  <= '0;
          bus_oe   <= 1'b0;
          op_count <= op_count + CNT_W'(1);
        end

        OUT_WAIT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            op_count  <= op_count + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/reg_move_sequencer.md
Name: reg_move_sequencer

Overview:
- Control stage directly upstream of the 8-bit register file.
- Accepts register-transfer micro-instructions over a valid/ready handshake.
- Drives the register file's r_addr/w_addr and the write side of the shared bus, one transfer at a time.
- Returns read results to the requester over a valid/ready output channel; sits between instruction decode and the register file.

Parameters:
- DATA_W, 8, bus and register data width.
- ADDR_W, 8, register address width.
- NULL_ADDR, 0, reserved address. The register file ignores writes to it and does not drive the bus when it is the read address.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept an instruction this cycle.
- instr_op  in  2  00 MOV, 01 LDI, 10 RD, 11 NOP.
- instr_dst  in  ADDR_W  destination register (MOV, LDI).
- instr_src  in  ADDR_W  source register (MOV, RD).
- instr_imm  in  DATA_W  immediate (LDI).
- r_addr  out  ADDR_W  read address to the register file.
- w_addr  out  ADDR_W  write address to the register file.
- bus_out  out  DATA_W  value driven onto the shared bus when bus_oe=1.
- bus_oe  out  1  sequencer drives the bus (top level builds the tristate).
- bus_in  in  DATA_W  sampled bus value.
- out_valid  out  1  RD result available.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_W  RD result.
- busy  out  1  state != IDLE.
- op_count  out  CNT_W  number of retired instructions.

Behaviour:
- States are IDLE, READ, WRITE and OUT_WAIT.
- Reset (rst_n=0 at an edge):
  - state returns to IDLE.
  - r_addr, w_addr, bus_out and out_data go to 0.
  - bus_oe, out_valid and busy go to 0.
  - op_count goes to 0.
  - The hold register clears.
  - Reset aborts any operation in progress; nothing partial is written after reset.
- instr_ready=1 only in IDLE. An instruction is accepted at an edge where instr_valid & instr_ready. Fields are latched at acceptance; input changes afterwards are ignored.
- IDLE:
  - r_addr=NULL_ADDR, w_addr=NULL_ADDR, bus_oe=0.
  - On accept: MOV or RD goes to READ; LDI goes to WRITE; NOP stays in IDLE and retires immediately.
- READ (1 cycle):
  - r_addr=src, w_addr=NULL_ADDR, bus_oe=0.
  - At the end of the cycle, hold <= bus_in. If src==NULL_ADDR, hold <= 0 (bus is undriven; X/Z must never be captured).
  - Next state: MOV goes to WRITE; RD goes to OUT_WAIT with out_data <= captured value and out_valid <= 1.
- WRITE (1 cycle):
  - r_addr=NULL_ADDR, w_addr=dst, bus_oe=1.
  - bus_out = hold (MOV) or imm (LDI).
  - Next state IDLE; retires.
  - dst==NULL_ADDR still performs the cycle; the register file discards the write.
- OUT_WAIT:
  - out_valid=1 and out_data stays stable until out_ready=1.
  - On that edge: out_valid <= 0, retire, go to IDLE.
  - out_ready=1 in the same cycle out_valid first rises completes the handshake in that cycle.
- Bus safety invariant: bus_oe=1 implies r_addr==NULL_ADDR in the same cycle. A bench assertion checks this every cycle.
- Registered outputs: r_addr, w_addr, bus_oe and bus_out are registered so they are glitch-free toward the register file.
- Latency from accept edge to next possible accept:
  - NOP: 1 cycle.
  - LDI: 2 cycles.
  - MOV: 3 cycles.
  - RD: 3 cycles plus any out_ready stall.
- Retire: op_count increments by 1 on every retire and wraps from 2^CNT_W-1 to 0.
- Simultaneous events:
  - rst_n=0 overrides everything.
  - instr_valid outside IDLE is held off with no side effect.

Test Plan:
- After reset, LDI dst=5 imm=0xA7 -> one cycle with w_addr=5, bus_oe=1, bus_out=0xA7, r_addr=0; op_count=1; instr_ready back after 2 cycles.
- With a register file model holding r5=0xA7: MOV src=5 dst=9 -> READ cycle has r_addr=5, bus_oe=0; next cycle has w_addr=9, bus_out=0xA7, bus_oe=1; r9 reads 0xA7 afterward.
- RD src=9 with out_ready held low 4 cycles -> out_valid=1, out_data=0xA7 stable for all 4 cycles, instr_ready=0 throughout; retires on the edge out_ready=1.
- RD src=0 with the bus left at Z -> out_data=0x00, no X; MOV src=3 dst=0 -> WRITE cycle has w_addr=0, register contents unchanged.
- rst_n pulled low during the READ cycle of a MOV -> next edge gives all outputs 0 and state IDLE; no WRITE cycle occurs; the bus_oe/r_addr invariant holds across 10,000 random instructions.
- op_count preset near wrap via 65,535 NOPs, then 2 more -> reads 0 then 1.
